// File: rtl/word_loader.sv
// Splits a valid/ready byte stream into delimiter-separated words, writes each
// word zero-terminated into the word SRAM and hands it to the encoder.
//
// state | meaning
// FILL  | accepting bytes, writing non-delimiters at address len
// TERM  | writing the zero terminator at address len
// ISSUE | word_start pulse, word_len/word_trunc valid
// WAIT  | input held off until the encoder returns enc_done
module word_loader #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM      = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  word_start,
  output logic [ADDR_WIDTH-1:0] word_len,
  output logic                  word_trunc,
  input  logic                  enc_done,
  output logic                  seq_done,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] MAXLEN = '1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_TERM  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic                  trunc_q, trunc_d;
  logic                  last_q, last_d;
  logic                  word_start_d, seq_done_d;
  logic [ADDR_WIDTH-1:0] word_len_d;
  logic                  word_trunc_d;
  logic                  is_delim;
  logic                  has_room;

  assign is_delim = (in_data == DELIM);
  assign has_room = (len_q != MAXLEN);
  assign busy     = (state_q != S_FILL) || (len_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FILL;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      last_q     <= 1'b0;
      word_start <= 1'b0;
      seq_done   <= 1'b0;
      word_len   <= '0;
      word_trunc <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
      last_q     <= last_d;
      word_start <= word_start_d;
      seq_done   <= seq_done_d;
      word_len   <= word_len_d;
      word_trunc <= word_trunc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    trunc_d      = trunc_q;
    last_d       = last_q;
    word_start_d = 1'b0;
    seq_done_d   = 1'b0;
    word_len_d   = word_len;
    word_trunc_d = word_trunc;
    in_ready     = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = len_q;
    mem_din      = in_data;

    case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!is_delim) begin
            if (has_room) begin
              mem_we = 1'b1;
              len_d  = len_q + 1'b1;
            end else begin
              trunc_d = 1'b1;
            end
          end
          // an empty word produces nothing, so runs of delimiters collapse
          if (is_delim || in_last) begin
            if (len_d == '0) begin
              seq_done_d = in_last;
            end else begin
              last_d  = in_last;
              state_d = S_TERM;
            end
          end
        end
      end
      S_TERM: begin
        mem_we       = 1'b1;
        mem_din      = '0;
        word_start_d = 1'b1;
        word_len_d   = len_q;
        word_trunc_d = trunc_q;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (enc_done) begin
          len_d      = '0;
          trunc_d    = 1'b0;
          last_d     = 1'b0;
          seq_done_d = last_q;
          state_d    = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_word_loader.sv
// Bench for word_loader: table of streams with hand-computed results, a reset
// in WAIT, and random streams, all checked against a word-level model.
module tb_word_loader;
  localparam int MAXLEN = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, enc_done;
  logic [7:0] in_data;
  logic       in_ready, mem_we, word_start, word_trunc, seq_done, busy;
  logic [3:0] mem_addr, word_len;
  logic [7:0] mem_din;

  word_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DELIM(8'h20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .word_start(word_start),
    .word_len(word_len), .word_trunc(word_trunc), .enc_done(enc_done),
    .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // event log captured on the falling edge
  bit         mon_en = 1'b0;
  logic [11:0] wr_log[$];
  logic [4:0]  ws_log[$];
  int seq_cnt = 0;
  int acc_cyc = -10;
  int enc_cyc = -10;
  bit done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (done_prev) chk("ready_after_done", in_ready, 1);
        done_prev = enc_done && !in_ready;
        if (done_prev) enc_cyc = cyc;
        if (mem_we) begin
          wr_log.push_back({mem_addr, mem_din});
          if (!in_ready) begin
            chk("term_latency", cyc, acc_cyc + 1);
            chk("term_data", mem_din, 0);
          end
        end
        if (word_start) begin
          ws_log.push_back({word_trunc, word_len});
          chk("start_latency", cyc, acc_cyc + 2);
        end
        if (seq_done) begin
          seq_cnt++;
          chk("seq_latency", int'((cyc == acc_cyc + 1) || (cyc == enc_cyc + 1)), 1);
        end
        if (in_valid && in_ready) acc_cyc = cyc;
      end
    end
  end

  // encoder stand-in: answers each word_start after a few cycles
  bit resp_en = 1'b1;
  int enc_delay_cfg = 0;
  initial begin
    enc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (word_start && resp_en && !rst) begin
        int d;
        d = (enc_delay_cfg > 0) ? enc_delay_cfg : int'($urandom_range(1, 4));
        repeat (d) @(posedge clk);
        #1 enc_done = 1'b1;
        @(posedge clk);
        #1 enc_done = 1'b0;
      end
    end
  end

  bit bubbles = 1'b0;

  task automatic send(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = last && (i == s.len() - 1);
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
          @(negedge clk);
          w++;
        end
        if (w >= 100) chk("ready_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // word-level reference: what the SRAM, encoder and sequencer should see
  task automatic run(input string s, input bit last);
    logic [11:0] ew[$];
    logic [4:0]  ei[$];
    int es, len, tr, n;
    logic [7:0] b;
    bit lst;
    es = 0; len = 0; tr = 0; n = s.len();
    for (int i = 0; i < n; i++) begin
      b   = s[i];
      lst = last && (i == n - 1);
      if (b != 8'h20) begin
        if (len < MAXLEN) begin
          ew.push_back({4'(len), b});
          len++;
        end else begin
          tr = 1;
        end
      end
      if (b == 8'h20 || lst) begin
        if (len > 0) begin
          ew.push_back({4'(len), 8'h00});
          ei.push_back({1'(tr), 4'(len)});
        end
        if (lst) es++;
        len = 0;
        tr  = 0;
      end
    end
    wr_log.delete();
    ws_log.delete();
    seq_cnt = 0;
    send(s, last);
    repeat (30) @(posedge clk);
    #1;
    chk("busy_idle", busy, 0);
    chk("writes_n", wr_log.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wr_log.size(); i++)
      chk("write_addr_data", wr_log[i], ew[i]);
    chk("starts_n", ws_log.size(), ei.size());
    for (int i = 0; i < ei.size() && i < ws_log.size(); i++)
      chk("start_trunc_len", ws_log[i], ei[i]);
    chk("seq_n", seq_cnt, es);
  endtask

  typedef struct {
    string text;
    bit    last;
    int    n_words;
    int    n_seq;
    int    n_writes;
    int    first_len;
    int    first_trunc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    string x20, y15, y16, s, one;
    int w;
    x20 = ""; y15 = ""; y16 = "";
    for (int i = 0; i < 20; i++) x20 = {x20, "x"};
    for (int i = 0; i < 15; i++) y15 = {y15, "y"};
    y16 = {y15, "y"};

    tbl[0] = '{"cat dog",      1'b1, 2, 1, 8,  3,  0};
    tbl[1] = '{"a   b",        1'b1, 2, 1, 4,  1,  0};
    tbl[2] = '{{x20, " ok "},  1'b0, 2, 0, 19, 15, 1};
    tbl[3] = '{" ",            1'b1, 0, 1, 0,  0,  0};
    tbl[4] = '{"hello",        1'b1, 1, 1, 6,  5,  0};
    tbl[5] = '{"  ab  cd ",    1'b0, 2, 0, 6,  2,  0};
    tbl[6] = '{y15,            1'b1, 1, 1, 16, 15, 0};
    tbl[7] = '{y16,            1'b1, 1, 1, 16, 15, 1};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_word_start", word_start, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_word_len", word_len, 0);
    chk("rst_word_trunc", word_trunc, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    enc_delay_cfg = 3;
    for (int k = 0; k < 8; k++) begin
      run(tbl[k].text, tbl[k].last);
      chk("tbl_words", ws_log.size(), tbl[k].n_words);
      chk("tbl_seq", seq_cnt, tbl[k].n_seq);
      chk("tbl_writes", wr_log.size(), tbl[k].n_writes);
      if (tbl[k].n_words > 0 && ws_log.size() > 0) begin
        chk("tbl_first_len", int'(ws_log[0][3:0]), tbl[k].first_len);
        chk("tbl_first_trunc", int'(ws_log[0][4]), tbl[k].first_trunc);
      end
    end
    enc_delay_cfg = 0;

    // reset while waiting on the encoder
    resp_en = 1'b0;
    send("ab ", 1'b0);
    w = 0;
    @(negedge clk);
    while (!word_start && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("wait_start_seen", int'(word_start), 1);
    chk("wait_len", word_len, 2);
    repeat (3) @(negedge clk);
    chk("wait_in_ready", in_ready, 0);
    chk("wait_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_word_len", word_len, 0);
    chk("abort_word_start", word_start, 0);
    chk("abort_seq_done", seq_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    resp_en = 1'b1;
    run("z", 1'b1);
    chk("z_len", ws_log.size() > 0 ? int'(ws_log[0][3:0]) : -1, 1);

    // random streams with input bubbles and random encoder latency
    bubbles = 1'b1;
    one = "a";
    for (int t = 0; t < 40; t++) begin
      int n;
      bit last;
      n = $urandom_range(1, 24);
      s = "";
      for (int i = 0; i < n; i++) begin
        int r;
        r = $urandom_range(0, 4);
        one[0] = (r == 0) ? 8'h20 : byte'(8'h60 + r);
        s = {s, one};
      end
      last = ($urandom_range(0, 3) != 0);
      if (!last) s = {s, " "};
      run(s, last);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_loader.md
Name: word_loader

Overview:
- Upstream feeder for the vocabulary-matching encoder.
- Accepts a byte stream with a valid/ready handshake and splits it into words on a delimiter byte.
- Writes each word, zero-terminated, into the word SRAM at addresses 0..len.
- Pulses `word_start` (drives the encoder's `cs`) and holds off further input until the encoder returns `enc_done`.

Parameters:
- `ADDR_WIDTH`, 4: word SRAM address width. Max word length `MAXLEN` = 2^ADDR_WIDTH − 1 bytes plus the terminator.
- `DATA_WIDTH`, 8: byte/SRAM data width.
- `DELIM`, 8'h20: delimiter byte value.

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input byte valid
- `in_data`  in  DATA_WIDTH  input byte
- `in_last`  in  1  marks the final byte of the stream (qualified by `in_valid`)
- `in_ready`  out  1  loader can accept a byte
- `mem_we`  out  1  word SRAM write enable
- `mem_addr`  out  ADDR_WIDTH  word SRAM address
- `mem_din`  out  DATA_WIDTH  word SRAM write data
- `word_start`  out  1  one-cycle pulse, a word is ready in SRAM (to encoder `cs`)
- `word_len`  out  ADDR_WIDTH  length of the handed-off word, excluding the terminator
- `word_trunc`  out  1  handed-off word was truncated
- `enc_done`  in  1  encoder has finished the current word (pulse or level, sampled in WAIT)
- `seq_done`  out  1  one-cycle pulse, stream fully processed
- `busy`  out  1  state != FILL, or `len` != 0

Behaviour:
- Reset (async, `rst`=1): state=FILL; `len`=0; `trunc`=0; `last_seen`=0.
  - Outputs: `word_start`=0, `seq_done`=0, `word_len`=0, `word_trunc`=0.
  - `mem_we`, `in_ready` and `busy` are combinational and follow the reset state: `in_ready`=1, `mem_we`=0, `busy`=0.
- Accept: a byte is accepted when `in_valid` & `in_ready`. `in_ready`=1 only in FILL.
- Memory writes are combinational with acceptance (zero latency):
  - `mem_we` = accept & (`in_data` != DELIM) & (`len` < MAXLEN).
  - `mem_addr` = `len`; `mem_din` = `in_data`; `len` increments on that edge.
  - TERM drives `mem_we`=1, `mem_addr`=`len`, `mem_din`=0.
  - Otherwise `mem_we`=0 and `mem_addr`/`mem_din` are don't-care.
- FILL:
  - Non-delimiter byte with `len` < MAXLEN: write it, `len`++.
  - Non-delimiter byte with `len` == MAXLEN: drop it (no write), set `trunc`=1.
  - End of word: delimiter accepted, or `in_last` accepted (with `in_last`, a non-delimiter byte is written first in the same cycle).
    - If `len` after this byte is 0: no word. If `in_last`, pulse `seq_done` next cycle and stay in FILL. Otherwise stay in FILL silently, so consecutive delimiters collapse.
    - If `len` after this byte is > 0: latch `last_seen` = `in_last`, go to TERM.
- TERM (1 cycle): write the terminator, then go to ISSUE.
- ISSUE (1 cycle):
  - `word_start`=1 for exactly one cycle.
  - `word_len`=`len` and `word_trunc`=`trunc`; both registered and held stable until the next ISSUE.
  - Go to WAIT.
- WAIT: `in_ready`=0. On `enc_done`=1:
  - Clear `len` and `trunc`; go to FILL.
  - If `last_seen`: pulse `seq_done` the following cycle and clear `last_seen`.
  - `enc_done` outside WAIT is ignored.
- Latency:
  - Last byte accepted at cycle t: terminator at t+1, `word_start` at t+2.
  - Delimiter accepted at t (word non-empty): terminator at t+1, `word_start` at t+2.
- Widths:
  - `len` is ADDR_WIDTH bits and saturates at MAXLEN, never wraps.
  - The terminator at address MAXLEN (2^ADDR_WIDTH − 1) is in range.
- Reset mid-word or mid-WAIT: abort immediately. Partially written SRAM contents are not cleared. No `word_start` or `seq_done` is emitted.
- Any `in_valid` without `in_ready` leaves all state unchanged. The upstream source must hold its byte (standard valid/ready).

Test Plan:
- "cat dog" with `in_last` on 'g', `enc_done` 3 cycles after each `word_start`:
  - SRAM writes 63,61,74,00 at addresses 0..3, then `word_start` with `word_len`=3.
  - Second word writes 64,6F,67,00 at addresses 0..3, `word_start`, `word_len`=3.
  - `seq_done` pulses one cycle after the second `enc_done`.
- "a␣␣␣b" + last: exactly two `word_start` pulses, `word_len`=1 each. Delimiters cause no writes.
- 20 'x' bytes then delimiter, ADDR_WIDTH=4:
  - 15 writes (addresses 0..14), terminator at address 15.
  - `word_len`=15, `word_trunc`=1.
  - Next word has `word_trunc`=0.
- Byte with `in_valid` held during WAIT: `in_ready`=0 and no write until `enc_done`; the byte is accepted on the first FILL cycle.
- Single delimiter with `in_last`: no `mem_we`, no `word_start`, `seq_done` pulses next cycle.
- Assert `rst` in WAIT after "ab":
  - Outputs return to reset values that cycle.
  - A new stream "z" + last yields writes 7A,00 at addresses 0..1, then `word_start` with `word_len`=1.
